// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: branch-predictor counter encodings, update FSM states, BTB field widths and record types.
package cpu_types_pkg;
    localparam int BTB_IDX_W = 2;
    localparam int BTB_TAG_W = 28;
    localparam int BTB_TGT_W = 30;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    typedef logic [1:0] upd_state_t;
    localparam logic [1:0] UPD_IDLE  = 2'd0;
    localparam logic [1:0] UPD_WRITE = 2'd1;
    localparam logic [1:0] UPD_PEND  = 2'd2;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] pc;
        logic        hit;
        ctr_t        hist;
    } track_t;

    typedef struct packed {
        logic [BTB_IDX_W-1:0] idx;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] tgt;
        ctr_t                 hist;
    } btb_wr_t;
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating branch counter.
module sat_counter2
    import cpu_types_pkg::*;
(
    input  ctr_t i_cnt,
    input  logic i_taken,
    output ctr_t o_cnt
);
    always_comb
        o_cnt = i_taken ? ((i_cnt == CTR_ST)  ? CTR_ST  : ctr_t'(i_cnt + 2'd1))
                        : ((i_cnt == CTR_SNT) ? CTR_SNT : ctr_t'(i_cnt - 2'd1));
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: BTB lookup and next-PC steering, EX-stage mispredict detection, serialized BTB update.
// Define BRANCH_STATS_EN to add the stat_branches / stat_mispredicts counters.
module branch_predict_ctrl
    import cpu_types_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [31:0]          fetch_pc,
    input  logic                 pipe_stall,
    input  logic                 branch_hit,
    input  logic [1:0]           branch_history,
    input  logic [BTB_TGT_W-1:0] target_address,
    output logic [BTB_IDX_W-1:0] mapping_sel,
    output logic [BTB_TAG_W-1:0] tag_bits,
    output logic                 slot_enabled,
    output logic [BTB_IDX_W-1:0] mapping_wsel,
    output logic [BTB_TAG_W-1:0] tag_bits_new,
    output logic [BTB_TGT_W-1:0] target_address_new,
    output logic [1:0]           branch_history_new,
    output logic                 btb_wen,
    input  logic                 resolve_valid,
    input  logic                 resolve_taken,
    input  logic [31:0]          resolve_pc,
    input  logic [31:0]          resolve_target,
    output logic                 predict_taken,
    output logic [31:0]          predict_pc,
    output logic                 mispredict,
    output logic [31:0]          correct_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
`endif
);
    track_t     r_q0, r_q1;
    btb_wr_t    r_cur, r_buf;
    upd_state_t r_state;
    track_t     w_fetch;
    btb_wr_t    w_req;
    ctr_t       w_next_cnt;
    logic       w_e_taken, w_e_hit, w_req_valid;

    always_comb begin
        mapping_sel   = fetch_pc[3:2];
        tag_bits      = fetch_pc[31:4];
        slot_enabled  = nRST;
        predict_taken = branch_hit & branch_history[1];
        predict_pc    = predict_taken ? {target_address, 2'b00} : fetch_pc + 32'd4;
    end

    assign w_fetch = '{valid: 1'b1, taken: predict_taken, pc: predict_pc, hit: branch_hit, hist: ctr_t'(branch_history)};

    // A flushed ID/EX entry behaves as a not-taken BTB miss.
    assign w_e_taken  = r_q1.valid & r_q1.taken;
    assign w_e_hit    = r_q1.valid & r_q1.hit;
    assign mispredict = nRST & resolve_valid &
                        ((resolve_taken != w_e_taken) | (resolve_taken & w_e_taken & (resolve_target != r_q1.pc)));
    assign correct_pc = resolve_taken ? resolve_target : resolve_pc + 32'd4;

    sat_counter2 u_sat (
        .i_cnt   (r_q1.hist),
        .i_taken (resolve_taken),
        .o_cnt   (w_next_cnt)
    );

    assign w_req_valid = resolve_valid & (w_e_hit | resolve_taken);
    assign w_req       = '{idx: resolve_pc[3:2], tag: resolve_pc[31:4], tgt: resolve_target[31:2],
                           hist: w_e_hit ? w_next_cnt : CTR_WT};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else if (mispredict) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else if (!pipe_stall) begin
            r_q0 <= w_fetch;
            r_q1 <= r_q0;
        end
    end

    // A request arriving while PEND replaces the buffered one: the newest update wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= UPD_IDLE;
            r_cur   <= '0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                UPD_IDLE: if (w_req_valid) begin
                    r_cur   <= w_req;
                    r_state <= UPD_WRITE;
                end
                UPD_WRITE: if (w_req_valid) begin
                    r_buf   <= w_req;
                    r_state <= UPD_PEND;
                end else begin
                    r_state <= UPD_IDLE;
                end
                UPD_PEND: begin
                    r_cur   <= w_req_valid ? w_req : r_buf;
                    r_state <= UPD_WRITE;
                end
                default: r_state <= UPD_IDLE;
            endcase
        end
    end

    assign btb_wen            = (r_state == UPD_WRITE);
    assign mapping_wsel       = r_cur.idx;
    assign tag_bits_new       = r_cur.tag;
    assign target_address_new = r_cur.tgt;
    assign branch_history_new = r_cur.hist;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_br, r_stat_mp;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else begin
            r_stat_br <= r_stat_br + {31'd0, resolve_valid};
            r_stat_mp <= r_stat_mp + {31'd0, mispredict};
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;
`endif
endmodule
